// File: rtl/mouse_receiver_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mouse_receiver_pkg : shared FSM encoding, error-bit positions, timeout default
// Revision 1.0
// ---------------------------------------------------------------------------
package mouse_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int PARITY_ERR             = 0;
  localparam int STOP_ERR               = 1;
  localparam int TIMEOUT_CYCLES_DEFAULT = 50000;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic parity_violated(input logic [7:0] data, input logic par);
    return ~(^data ^ par);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_edge_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_edge_sync : 2-flop synchronisers for PS/2 clock and data, clock fall detect
// Revision 1.0
// ---------------------------------------------------------------------------
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;

  // Reset to the idle-bus level so release never fakes a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign data_sync = r_data_sync[1];
  assign clk_fall  = r_clk_prev & ~r_clk_sync[1];

endmodule
`default_nettype wire

// File: rtl/mouse_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mouse_receiver : PS/2 device-to-host frame receiver with parity/stop checks
// Revision 1.0
// ---------------------------------------------------------------------------
module mouse_receiver
  import mouse_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [CW-1:0]   r_timeout;
  logic [7:0]      r_shift;
  logic [1:0]      r_err;

  logic            w_data;
  logic            w_fall;
  logic            w_timeout;

  ps2_edge_sync u_sync (
    .clk       (CLK),
    .rst       (RESET),
    .ps2_clk   (CLK_MOUSE_IN),
    .ps2_data  (DATA_MOUSE_IN),
    .data_sync (w_data),
    .clk_fall  (w_fall)
  );

  assign w_timeout = (r_timeout == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state         <= IDLE;
      r_bit_cnt       <= 3'd0;
      r_timeout       <= '0;
      r_shift         <= 8'h00;
      r_err           <= 2'b00;
      BYTE_READ       <= 8'h00;
      BYTE_ERROR_CODE <= 2'b00;
      BYTE_READY      <= 1'b0;
    end else begin
      BYTE_READY <= 1'b0;

      if (r_state == IDLE || w_fall)
        r_timeout <= '0;
      else
        r_timeout <= r_timeout + CW'(1);

      // Losing the bus to the transmitter discards whatever was in flight.
      if (!READ_ENABLE) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_fall && !w_data) begin
              r_state   <= DATA;
              r_bit_cnt <= 3'd0;
              r_err     <= 2'b00;
            end
          end
          DATA: begin
            if (w_fall) begin
              r_shift   <= {w_data, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7)
                r_state <= PARITY;
            end else if (w_timeout) begin
              r_state <= IDLE;
            end
          end
          PARITY: begin
            if (w_fall) begin
              r_err[PARITY_ERR] <= parity_violated(r_shift, w_data);
              r_state           <= STOP;
            end else if (w_timeout) begin
              r_state <= IDLE;
            end
          end
          STOP: begin
            if (w_fall) begin
              r_err[STOP_ERR] <= ~w_data;
              r_state         <= DONE;
            end else if (w_timeout) begin
              r_state <= IDLE;
            end
          end
          DONE: begin
            BYTE_READ       <= r_shift;
            BYTE_ERROR_CODE <= r_err;
            BYTE_READY      <= 1'b1;
            r_state         <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mouse_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mouse_receiver : directed PS/2 frames against hand-computed byte/error results
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mouse_receiver;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       read_en  = 1'b1;
  logic [7:0] byte_read;
  logic [1:0] err_code;
  logic       ready;

  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  mouse_receiver dut (
    .CLK             (clk),
    .RESET           (rst),
    .CLK_MOUSE_IN    (ps2_clk),
    .DATA_MOUSE_IN   (ps2_data),
    .READ_ENABLE     (read_en),
    .BYTE_READ       (byte_read),
    .BYTE_ERROR_CODE (err_code),
    .BYTE_READY      (ready)
  );

  always @(negedge clk)
    if (ready) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One PS/2 bit: data set mid-high phase, clock low 20 cycles, high 20 cycles.
  // lat = first rising CLK edge (1-based, after the fall) where BYTE_READY is seen.
  task automatic send_bit(input logic b, output int lat);
    lat = 0;
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ready && lat == 0) lat = i;
    end
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, output int lat);
    logic [10:0] f;
    int          l;
    f   = {stop, par, d, 1'b0};
    lat = 0;
    for (int i = 0; i < nbits; i++) begin
      send_bit(f[i], l);
      if (i == nbits - 1) lat = l;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame_check(input string tag, input logic [7:0] d, input logic par,
                             input logic stop, input logic [1:0] exp_err);
    int p0;
    int lat;
    p0 = pulse_cnt;
    send_frame(d, par, stop, 11, lat);
    repeat (5) @(negedge clk);
    check({tag, "_pulses"}, pulse_cnt - p0, 1);
    check({tag, "_byte"}, byte_read, d);
    check({tag, "_err"}, err_code, exp_err);
  endtask

  initial begin
    int p0;
    int lat;

    #1;
    check("rst_byte", byte_read, 8'h00);
    check("rst_err", err_code, 2'b00);
    check("rst_ready", ready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_ready", ready, 1'b0);

    // 0xFA has six ones, so parity 1 is correct; also measure pulse latency.
    p0 = pulse_cnt;
    send_frame(8'hFA, 1'b1, 1'b1, 11, lat);
    repeat (5) @(negedge clk);
    check("fa_latency", lat, 4);
    check("fa_pulses", pulse_cnt - p0, 1);
    check("fa_byte", byte_read, 8'hFA);
    check("fa_err", err_code, 2'b00);

    // 0x08 has one one; parity 1 makes the total even -> parity error.
    frame_check("par_err", 8'h08, 1'b1, 1'b1, 2'b01);
    frame_check("stop_err", 8'h00, 1'b1, 1'b0, 2'b10);
    // 0x03 has two ones; parity 0 wrong and stop 0 wrong.
    frame_check("both_err", 8'h03, 1'b0, 1'b0, 2'b11);

    // Partial frame (start + 4 data bits), then a stall past the timeout.
    p0 = pulse_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 5, lat);
    repeat (60000) @(negedge clk);
    check("to_pulses", pulse_cnt - p0, 0);
    check("to_hold_byte", byte_read, 8'h03);
    check("to_hold_err", err_code, 2'b11);
    frame_check("after_to", 8'hAA, 1'b1, 1'b1, 2'b00);

    // Full frame while the transmitter owns the bus.
    read_en = 1'b0;
    p0 = pulse_cnt;
    send_frame(8'h55, 1'b1, 1'b1, 11, lat);
    repeat (10) @(negedge clk);
    check("dis_pulses", pulse_cnt - p0, 0);
    check("dis_hold", byte_read, 8'hAA);
    read_en = 1'b1;
    repeat (10) @(negedge clk);

    // Drop READ_ENABLE mid-frame, then a clean frame must arrive intact.
    p0 = pulse_cnt;
    send_frame(8'h55, 1'b1, 1'b1, 4, lat);
    read_en = 1'b0;
    repeat (20) @(negedge clk);
    read_en = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_pulses", pulse_cnt - p0, 0);
    frame_check("after_abort", 8'h3C, 1'b1, 1'b1, 2'b00);

    // Asynchronous reset while bit 4 is due; outputs must clear at once.
    send_frame(8'hF4, 1'b0, 1'b1, 4, lat);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_byte", byte_read, 8'h00);
    check("mid_rst_err", err_code, 2'b00);
    check("mid_rst_ready", ready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // 0xF4 has five ones, so parity 0 is correct.
    frame_check("after_rst", 8'hF4, 1'b0, 1'b1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
